// File: rtl/cla_16.sv
// 16-bit two-level carry-lookahead adder with registered sum, carry-out and group G/P.
// Four 4-bit lookahead slices feed a second-level lookahead carry unit.

module cla_16_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       g_grp,
  output logic       p_grp
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g = x & y;
    p = x ^ y;

    // Carries flattened to sum-of-products so no bit waits on its neighbour.
    c[0] = cin;
    c[1] = g[0]
         | (p[0] & cin);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & cin);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);

    sum = p ^ c;

    g_grp = g[3]
          | (p[3] & g[2])
          | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]);
    p_grp = &p;
  end

endmodule

module cla_16_lcu (
  input  logic [3:0] g_blk,
  input  logic [3:0] p_blk,
  input  logic       c0,
  output logic [4:1] c_blk,
  output logic       g_grp,
  output logic       p_grp
);

  always_comb begin
    c_blk[1] = g_blk[0]
             | (p_blk[0] & c0);
    c_blk[2] = g_blk[1]
             | (p_blk[1] & g_blk[0])
             | (p_blk[1] & p_blk[0] & c0);
    c_blk[3] = g_blk[2]
             | (p_blk[2] & g_blk[1])
             | (p_blk[2] & p_blk[1] & g_blk[0])
             | (p_blk[2] & p_blk[1] & p_blk[0] & c0);

    g_grp = g_blk[3]
          | (p_blk[3] & g_blk[2])
          | (p_blk[3] & p_blk[2] & g_blk[1])
          | (p_blk[3] & p_blk[2] & p_blk[1] & g_blk[0]);
    p_grp = &p_blk;

    // Carry-out kept in the G | P&c0 form so it matches the exported group terms.
    c_blk[4] = g_grp | (p_grp & c0);
  end

endmodule

module cla_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        c0,
  output logic        G,
  output logic        P,
  output logic        c16,
  output logic [15:0] s
);

  logic [3:0]  g_blk;
  logic [3:0]  p_blk;
  logic [4:0]  c_blk;
  logic [15:0] sum_comb;
  logic        g_top;
  logic        p_top;

  logic [15:0] s_d, s_q;
  logic        c16_d, c16_q;
  logic        g_d, g_q;
  logic        p_d, p_q;

  assign c_blk[0] = c0;

  for (genvar k = 0; k < 4; k++) begin : g_slice
    cla_16_slice u_slice (
      .x     (x[4*k +: 4]),
      .y     (y[4*k +: 4]),
      .cin   (c_blk[k]),
      .sum   (sum_comb[4*k +: 4]),
      .g_grp (g_blk[k]),
      .p_grp (p_blk[k])
    );
  end

  cla_16_lcu u_lcu (
    .g_blk (g_blk),
    .p_blk (p_blk),
    .c0    (c0),
    .c_blk (c_blk[4:1]),
    .g_grp (g_top),
    .p_grp (p_top)
  );

  always_comb begin
    s_d   = sum_comb;
    c16_d = c_blk[4];
    g_d   = g_top;
    p_d   = p_top;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q   <= 16'h0000;
      c16_q <= 1'b0;
      g_q   <= 1'b0;
      p_q   <= 1'b0;
    end else begin
      s_q   <= s_d;
      c16_q <= c16_d;
      g_q   <= g_d;
      p_q   <= p_d;
    end
  end

  assign s   = s_q;
  assign c16 = c16_q;
  assign G   = g_q;
  assign P   = p_q;

endmodule

// File: tb/tb_cla_16.sv
// Scoreboard bench for cla_16: reference results queued at drive time, popped one edge later.

module tb_cla_16;

  logic        clk;
  logic        rst;
  logic [15:0] x;
  logic [15:0] y;
  logic        c0;
  logic        G;
  logic        P;
  logic        c16;
  logic [15:0] s;

  typedef struct {
    logic [15:0] s;
    logic        c16;
    logic        g;
    logic        p;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  cla_16 dut (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .y   (y),
    .c0  (c0),
    .G   (G),
    .P   (P),
    .c16 (c16),
    .s   (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic ci);
    exp_t e;
    logic [16:0] full;
    logic [16:0] no_cin;
    full   = {1'b0, a} + {1'b0, b} + {16'h0000, ci};
    no_cin = {1'b0, a} + {1'b0, b};
    e.s   = full[15:0];
    e.c16 = full[16];
    e.g   = no_cin[16];
    e.p   = ((a ^ b) == 16'hFFFF);
    return e;
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_s"},   {16'h0, s},   {16'h0, e.s});
    chk({tag, "_c16"}, {31'h0, c16}, {31'h0, e.c16});
    chk({tag, "_G"},   {31'h0, G},   {31'h0, e.g});
    chk({tag, "_P"},   {31'h0, P},   {31'h0, e.p});
  endtask

  task automatic drive(input string tag, input logic [15:0] a, input logic [15:0] b, input logic ci);
    @(negedge clk);
    x  = a;
    y  = b;
    c0 = ci;
    sb.push_back(model(a, b, ci));
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s"},   {16'h0, s},   32'h0);
    chk({tag, "_c16"}, {31'h0, c16}, 32'h0);
    chk({tag, "_G"},   {31'h0, G},   32'h0);
    chk({tag, "_P"},   {31'h0, P},   32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    x   = 16'h0;
    y   = 16'h0;
    c0  = 1'b0;
    #3;
    check_zero("reset");

    @(negedge clk);
    rst = 1'b0;

    drive("zero",      16'h0000, 16'h0000, 1'b0);
    drive("six_nine",  16'h0006, 16'h0009, 1'b0);
    drive("one_one_c", 16'h0001, 16'h0001, 1'b1);
    drive("prop_all",  16'hFFFF, 16'h0000, 1'b1);
    drive("gen_msb",   16'h8000, 16'h8000, 1'b0);
    drive("prop_noc",  16'h5555, 16'hAAAA, 1'b0);
    drive("all_ones",  16'hFFFF, 16'hFFFF, 1'b1);
    drive("slice_hop", 16'h0FFF, 16'h0001, 1'b0);
    drive("mid_carry", 16'h00F0, 16'h0010, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      drive("rand", 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset between edges with nonzero outputs present.
    drive("pre_rst", 16'h1234, 16'h4321, 1'b1);
    @(negedge clk);
    x  = 16'hDEAD;
    y  = 16'hBEEF;
    c0 = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    @(posedge clk);
    #1;
    check_zero("rst_held");
    @(negedge clk);
    x  = 16'h00FF;
    y  = 16'h0001;
    c0 = 1'b1;
    #1;
    rst = 1'b0;
    sb.push_back(model(16'h00FF, 16'h0001, 1'b1));
    @(posedge clk);
    #1;
    pop_check("rst_release");

    drive("post_rst", 16'hFFFF, 16'h0001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
